// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the control unit and the sequential divider.
// The master side starts an operation; the slave side (the divider) returns HI/LO and status.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                    start;
    logic signed [WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0] divisor;
    logic signed [WIDTH-1:0] hi;
    logic signed [WIDTH-1:0] lo;
    logic                    busy;
    logic                    done;
    logic                    div_zero;

    modport master (
        output start, dividend, divisor,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider for MIPS DIV: quotient to LO, remainder to HI.
// Truncates toward zero; the remainder carries the dividend's sign.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic          clock,
    input logic          reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN, ZERO} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                           input logic neg);
        return neg ? -$signed(m) : $signed(m);
    endfunction

    // The remainder is always below |divisor| <= 2^(WIDTH-1), so only the shifted
    // compare needs WIDTH+1 bits; the difference itself fits in WIDTH bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs});
        diff    = shifted[WIDTH-1:0] - dvs;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) state_next = (bus.divisor == '0) ? ZERO : CALC;
            end
            CALC: begin
                if (cnt == '0) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.divisor != '0) begin
                        quo    <= magnitude(bus.dividend);
                        dvs    <= magnitude(bus.divisor);
                        rem    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r <= bus.dividend[WIDTH-1];
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        rem <= fits ? diff : shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], fits};
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.lo <= apply_sign(quo, sign_q);
                        bus.hi <= apply_sign(rem, sign_r);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags decode straight from the state register, so they are glitch-free pulses.
    assign bus.busy     = (state == CALC);
    assign bus.done     = (state == FIN) || (state == ZERO);
    assign bus.div_zero = (state == ZERO);
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signs, latency, divide-by-zero, boundaries,
// ignored start, mid-operation reset and back-to-back operation.
module tb_seq_divider;
    logic clock = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clock = ~clock;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until done is seen (bounded); n is the number of edges consumed.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 100);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   n;
        logic busy_ok;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        n       = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({tag, " latency"}, n, 33);
        check({tag, " busy_held"}, busy_ok, 1'b1);
        check({tag, " lo"}, bus.lo, exp_lo);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " busy_at_done"}, bus.busy, 1'b0);
        check({tag, " flag_at_done"}, bus.div_zero, 1'b0);
        tick();
        check({tag, " done_one_cycle"}, bus.done, 1'b0);
    endtask

    initial begin
        int   n;
        logic seen_done;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst hi", bus.hi, 32'h0);
        check("rst lo", bus.lo, 32'h0);
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst div_zero", bus.div_zero, 1'b0);

        run_op("7/2", 32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001);
        run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
        run_op("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);

        // Divide by zero must leave the preloaded results alone.
        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
        bus.start    = 1'b1;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd0;
        tick();
        bus.start = 1'b0;
        check("zero done", bus.done, 1'b1);
        check("zero flag", bus.div_zero, 1'b1);
        check("zero busy", bus.busy, 1'b0);
        check("zero hi", bus.hi, 32'd2);
        check("zero lo", bus.lo, 32'd14);
        tick();
        check("zero done_clear", bus.done, 1'b0);
        check("zero flag_clear", bus.div_zero, 1'b0);
        check("zero busy_after", bus.busy, 1'b0);

        run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        run_op("min/min", 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h0);
        run_op("max/min", 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF);
        run_op("0/5", 32'h0, 32'd5, 32'h0, 32'h0);

        // A start pulse during CALC is dropped.
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        tick();
        bus.start = 1'b0;
        wait_done(n);
        check("ignore latency", n + 5, 33);
        check("ignore lo", bus.lo, 32'd14);
        check("ignore hi", bus.hi, 32'd2);
        tick();

        // Reset mid-operation aborts without a done pulse.
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort hi", bus.hi, 32'h0);
        check("abort lo", bus.lo, 32'h0);
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("abort no_done", seen_done, 1'b0);
        run_op("50/5", 32'd50, 32'd5, 32'd10, 32'd0);

        // Start held high: operations run back to back.
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        wait_done(n);
        check("b2b first latency", n, 34);
        check("b2b first lo", bus.lo, 32'd3);
        check("b2b first hi", bus.hi, 32'd0);
        for (int k = 0; k < 2; k++) begin
            wait_done(n);
            check("b2b period", n, 35);
            check("b2b lo", bus.lo, 32'd3);
            check("b2b hi", bus.hi, 32'd0);
            check("b2b busy", bus.busy, 1'b0);
        end
        bus.start = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
